eth_hdr_axis_tx: RTL and testbench
==================================

# eth_hdr_axis_tx

Ethernet frame serializer that sits directly downstream of the ARP frame transmitter. It accepts a parallel Ethernet header (destination MAC, source MAC, ethertype) plus an 8-bit AXI-stream payload and emits one byte-serial AXI-stream frame toward the MAC. The frame is the 14-byte header followed by the payload, optionally zero-padded to a minimum length. It decouples header acceptance from payload streaming and carries a registered, skid-buffered output.

## Interface
- DATA_WIDTH, 8, stream width; only 8 is legal, any other value is an elaboration error.
- ENABLE_PADDING, 1, when 1, pad short frames with zero bytes.
- MIN_FRAME_LENGTH, 60, minimum frame length in bytes (header plus payload, excluding FCS); legal range 15..65535.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset; one clock, reset asynchronous and active-low.
- s_eth_hdr_valid / s_eth_hdr_ready  in/out  1  header handshake.
- s_eth_dest_mac, s_eth_src_mac  in  48  MACs; byte [47:40] is sent first.
- s_eth_type  in  16  ethertype; [15:8] is sent first.
- s_eth_payload_axis_tdata  in  8  payload byte.
- s_eth_payload_axis_tvalid / tready / tlast / tuser  in/out/in/in  1  payload stream.
- m_axis_tdata  out  8  frame byte.
- m_axis_tvalid / tready / tlast / tuser  out/in/out/out  1  frame stream.
- busy  out  1  high from header acceptance until the last frame byte enters the output stage.

## Operation
- FSM states: IDLE, HEADER, PAYLOAD, PAD.
- IDLE:
  - s_eth_hdr_ready is registered and high only in IDLE with no pending frame.
  - On a header handshake, latch all header fields, clear ptr and frame counter, go to HEADER.
- HEADER: emits 14 bytes, one per cycle when the internal ready is high: dest[47:0], then src[47:0], then type, each MSB-first. After byte 13, go to PAYLOAD.
- PAYLOAD:
  - s_eth_payload_axis_tready equals internal ready and is gated to the PAYLOAD state.
  - Each accepted byte passes through with its tuser.
  - On the tlast beat, if ENABLE_PADDING and frame count + 1 < MIN_FRAME_LENGTH: suppress tlast and tuser on that beat and go to PAD. Otherwise emit tlast and tuser and go to IDLE.
- PAD: emits 0x00 bytes until the frame count reaches MIN_FRAME_LENGTH. The last pad byte carries tlast=1 and the latched tuser of the final payload beat, then the FSM goes to IDLE.
- Frame counter: 16-bit, counts bytes emitted into the output stage, and saturates at 0xFFFF.
- Payload tvalid low in PAYLOAD: insert output bubbles only. There is no underflow error and no timeout.
- Header valid during busy: held off by hdr_ready=0; the header is not lost.
- Reset values: s_eth_hdr_ready=0, s_eth_payload_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdata=0, busy=0, FSM=IDLE, skid buffer empty.

## Timing
- Header handshake at edge T: the first header byte is valid on m_axis in the cycle following edge T+2 when m_axis_tready is held high.
- Throughput: 1 byte per cycle sustained across the header, payload and pad states.
- Between frames: at most 2 idle output cycles with continuous input.
- Output backpressure: internal ready is registered (early-ready plus temp register).
  - No byte is dropped or duplicated.
  - m_axis_tdata, tlast and tuser are stable while tvalid && !tready.
  - Internal ready may lag by one cycle, and the temp register absorbs that.
- Reset mid-frame (rst_n low at any time):
  - All valids and readies clear immediately and asynchronously.
  - The partial frame is abandoned without tlast.
  - s_eth_hdr_ready rises on the first clock edge after rst_n deasserts.

## Structure
- Package eth_pkg holds: ETH_HDR_LEN=14, the FSM state enum, and MAC_W=48 / TYPE_W=16 localparams.
- Sub-module axis_skid_reg holds the output register plus temp register and produces tready_int_early. It is reused by other TX stages.
- Top level holds the FSM, the header shift select, the counters and the pad logic.

## Test plan
- ARP-size frame, ready always high:
  - Stimulus: dest ff:ff:ff:ff:ff:ff, src 02:00:00:00:00:01, type 0x0806, payload 0x01..0x1C (28 bytes).
  - Expected: 60 bytes = ff×6, 02 00 00 00 00 01, 08 06, 01..1C, 00×18; tlast only on byte 60.
- ENABLE_PADDING=0 with the same stimulus: expect 42 bytes, tlast on byte 42, no zeros appended.
- 100-byte payload 0x00..0x63: expect 114 bytes, no padding, tlast on byte 114, busy low within 2 cycles after the tlast beat transfers.
- Backpressure: m_axis_tready follows a random 50% pattern, and payload tvalid also gaps randomly.
  - Expected: the byte stream is identical to the no-stall run.
  - Expected: outputs are stable during stalls and no byte is lost or duplicated.
- tuser on the last beat of a 10-byte payload: expect 60-byte output with tuser=1 only on byte 60 alongside tlast.
- rst_n pulsed low at payload byte 5:
  - During reset: m_axis_tvalid=0 and busy=0 in the same cycle.
  - After release: hdr_ready returns 1 edge after release, and the next frame is emitted correctly from its first byte.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet header transmit path.
package eth_pkg;

  localparam int ETH_HDR_LEN = 14;
  localparam int MAC_W       = 48;
  localparam int TYPE_W      = 16;

  typedef logic [1:0] eth_tx_state_t;
  localparam eth_tx_state_t ST_IDLE    = 2'd0;
  localparam eth_tx_state_t ST_HEADER  = 2'd1;
  localparam eth_tx_state_t ST_PAYLOAD = 2'd2;
  localparam eth_tx_state_t ST_PAD     = 2'd3;

  // Field order matches wire order: dest first, ethertype last.
  typedef struct packed {
    logic [MAC_W-1:0]  dest;
    logic [MAC_W-1:0]  src;
    logic [TYPE_W-1:0] ethertype;
  } eth_hdr_t;

  function automatic logic [7:0] hdr_byte(input eth_hdr_t hdr, input logic [3:0] idx);
    logic [8*ETH_HDR_LEN-1:0] flat;
    flat = hdr;
    flat = flat << {idx, 3'b000};
    return flat[8*ETH_HDR_LEN-1 -: 8];
  endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// Registered AXI-stream output stage with a one-beat temp register, so the
// producer can work from a registered ready that lags the sink by one cycle.
module axis_skid_reg #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] tdata_int,
  input  logic          tvalid_int,
  input  logic          tlast_int,
  input  logic          tuser_int,
  output logic          tready_int,
  output logic [DW-1:0] m_axis_tdata,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic          m_axis_tlast,
  output logic          m_axis_tuser
);

  typedef struct packed {
    logic          last;
    logic          user;
    logic [DW-1:0] data;
  } beat_t;

  beat_t in_beat;
  beat_t out_q, out_d, temp_q, temp_d;
  logic  out_valid_q, out_valid_d;
  logic  temp_valid_q, temp_valid_d;
  logic  tready_int_q, tready_int_early;

  assign in_beat = '{last: tlast_int, user: tuser_int, data: tdata_int};

  // Ready next cycle unless the temp slot is occupied or is about to be.
  assign tready_int_early = m_axis_tready || (!temp_valid_q && (!out_valid_q || !tvalid_int));

  // NOTE: every always_comb output is given a default first, so no latch is inferred.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    temp_d       = temp_q;
    temp_valid_d = temp_valid_q;
    if (tready_int_q) begin
      if (m_axis_tready || !out_valid_q) begin
        out_valid_d = tvalid_int;
        out_d       = in_beat;
      end else begin
        temp_valid_d = tvalid_int;
        temp_d       = in_beat;
      end
    end else if (m_axis_tready) begin
      out_valid_d  = temp_valid_q;
      out_d        = temp_q;
      temp_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      temp_q       <= '0;
      temp_valid_q <= 1'b0;
      tready_int_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      temp_q       <= temp_d;
      temp_valid_q <= temp_valid_d;
      tready_int_q <= tready_int_early;
    end
  end

  assign tready_int    = tready_int_q;
  assign m_axis_tdata  = out_q.data;
  assign m_axis_tlast  = out_q.last;
  assign m_axis_tuser  = out_q.user;
  assign m_axis_tvalid = out_valid_q;

endmodule

// File: rtl/eth_hdr_axis_tx.sv
// Serialises a parallel Ethernet header plus byte payload into one AXI-stream
// frame, zero-padding short frames up to MIN_FRAME_LENGTH when enabled.
module eth_hdr_axis_tx
  import eth_pkg::*;
#(
  parameter int DATA_WIDTH       = 8,
  parameter int ENABLE_PADDING   = 1,
  parameter int MIN_FRAME_LENGTH = 60
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_eth_hdr_valid,
  output logic                  s_eth_hdr_ready,
  input  logic [MAC_W-1:0]      s_eth_dest_mac,
  input  logic [MAC_W-1:0]      s_eth_src_mac,
  input  logic [TYPE_W-1:0]     s_eth_type,
  input  logic [DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
  input  logic                  s_eth_payload_axis_tvalid,
  output logic                  s_eth_payload_axis_tready,
  input  logic                  s_eth_payload_axis_tlast,
  input  logic                  s_eth_payload_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  busy
);

  if (DATA_WIDTH != 8) begin : g_bad_width
    $error("eth_hdr_axis_tx: DATA_WIDTH must be 8");
  end
  if (MIN_FRAME_LENGTH < 15 || MIN_FRAME_LENGTH > 65535) begin : g_bad_min_len
    $error("eth_hdr_axis_tx: MIN_FRAME_LENGTH must be within 15..65535");
  end

  localparam logic [16:0] MIN_LEN = 17'(MIN_FRAME_LENGTH);

  eth_tx_state_t state_q, state_d;
  eth_hdr_t      hdr_q, hdr_d;
  logic [3:0]    ptr_q, ptr_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          launch_q, launch_d;
  logic          pad_tuser_q, pad_tuser_d;
  logic          hdr_ready_q, hdr_ready_d;
  logic          busy_q, busy_d;

  logic [DATA_WIDTH-1:0] tdata_int;
  logic        tvalid_int, tlast_int, tuser_int, tready_int;
  logic        payload_ready;
  logic [16:0] cnt_inc;
  logic [15:0] cnt_sat;

  // cnt_inc is the frame length including the byte emitted this cycle.
  assign cnt_inc = {1'b0, cnt_q} + 17'd1;
  assign cnt_sat = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    launch_d    = launch_q;
    pad_tuser_d = pad_tuser_q;
    tdata_int   = '0;
    tvalid_int  = 1'b0;
    tlast_int   = 1'b0;
    tuser_int   = 1'b0;
    payload_ready = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (s_eth_hdr_valid && hdr_ready_q) begin
          hdr_d.dest      = s_eth_dest_mac;
          hdr_d.src       = s_eth_src_mac;
          hdr_d.ethertype = s_eth_type;
          ptr_d    = '0;
          cnt_d    = '0;
          launch_d = 1'b0;
          state_d  = ST_HEADER;
        end
      end
      ST_HEADER: begin
        // One launch cycle after acceptance puts the first byte out two edges later.
        if (!launch_q) begin
          launch_d = 1'b1;
        end else if (tready_int) begin
          tvalid_int = 1'b1;
          tdata_int  = hdr_byte(hdr_q, ptr_q);
          ptr_d      = ptr_q + 4'd1;
          cnt_d      = cnt_sat;
          if (ptr_q == 4'(ETH_HDR_LEN - 1)) state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        payload_ready = tready_int;
        if (s_eth_payload_axis_tvalid && tready_int) begin
          tvalid_int = 1'b1;
          tdata_int  = s_eth_payload_axis_tdata;
          tuser_int  = s_eth_payload_axis_tuser;
          cnt_d      = cnt_sat;
          if (s_eth_payload_axis_tlast) begin
            if (ENABLE_PADDING != 0 && cnt_inc < MIN_LEN) begin
              tuser_int   = 1'b0;
              pad_tuser_d = s_eth_payload_axis_tuser;
              state_d     = ST_PAD;
            end else begin
              tlast_int = 1'b1;
              state_d   = ST_IDLE;
            end
          end
        end
      end
      ST_PAD: begin
        if (tready_int) begin
          tvalid_int = 1'b1;
          cnt_d      = cnt_sat;
          if (cnt_inc >= MIN_LEN) begin
            tlast_int = 1'b1;
            tuser_int = pad_tuser_q;
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    hdr_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  // NOTE: header and counter flops are reset too so nothing comes up unknown; only true memory arrays would be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hdr_q       <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      launch_q    <= 1'b0;
      pad_tuser_q <= 1'b0;
      hdr_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      launch_q    <= launch_d;
      pad_tuser_q <= pad_tuser_d;
      hdr_ready_q <= hdr_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign s_eth_hdr_ready           = hdr_ready_q;
  assign s_eth_payload_axis_tready = payload_ready;
  assign busy                      = busy_q;

  axis_skid_reg #(.DW(DATA_WIDTH)) u_out (
    .clk           (clk),
    .rst_n         (rst_n),
    .tdata_int     (tdata_int),
    .tvalid_int    (tvalid_int),
    .tlast_int     (tlast_int),
    .tuser_int     (tuser_int),
    .tready_int    (tready_int),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser)
  );

endmodule

// File: tb/tb_eth_hdr_axis_tx.sv
// Bench for eth_hdr_axis_tx: table of frames checked through a byte scoreboard,
// plus hand-written reset and latency sequences.
module tb_eth_hdr_axis_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sel_np;
  logic        stall_mode;
  logic        sb_en;
  logic        hdr_valid;
  logic [47:0] dest, src;
  logic [15:0] etype;
  logic [7:0]  p_tdata;
  logic        p_tvalid, p_tlast, p_tuser;
  logic        m_tready = 1'b1;

  logic       hdr_ready_a, hdr_ready_b, p_tready_a, p_tready_b;
  logic [7:0] tdata_a, tdata_b;
  logic       tvalid_a, tvalid_b, tlast_a, tlast_b, tuser_a, tuser_b, busy_a, busy_b;

  logic       hdr_ready, p_tready, m_tvalid, m_tlast, m_tuser, busy;
  logic [7:0] m_tdata;
  assign hdr_ready = sel_np ? hdr_ready_b : hdr_ready_a;
  assign p_tready  = sel_np ? p_tready_b  : p_tready_a;
  assign m_tdata   = sel_np ? tdata_b     : tdata_a;
  assign m_tvalid  = sel_np ? tvalid_b    : tvalid_a;
  assign m_tlast   = sel_np ? tlast_b     : tlast_a;
  assign m_tuser   = sel_np ? tuser_b     : tuser_a;
  assign busy      = sel_np ? busy_b      : busy_a;

  eth_hdr_axis_tx #(.DATA_WIDTH(8), .ENABLE_PADDING(1), .MIN_FRAME_LENGTH(60)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_eth_hdr_valid(hdr_valid & ~sel_np), .s_eth_hdr_ready(hdr_ready_a),
    .s_eth_dest_mac(dest), .s_eth_src_mac(src), .s_eth_type(etype),
    .s_eth_payload_axis_tdata(p_tdata), .s_eth_payload_axis_tvalid(p_tvalid & ~sel_np),
    .s_eth_payload_axis_tready(p_tready_a), .s_eth_payload_axis_tlast(p_tlast),
    .s_eth_payload_axis_tuser(p_tuser),
    .m_axis_tdata(tdata_a), .m_axis_tvalid(tvalid_a), .m_axis_tready(m_tready),
    .m_axis_tlast(tlast_a), .m_axis_tuser(tuser_a), .busy(busy_a)
  );

  eth_hdr_axis_tx #(.DATA_WIDTH(8), .ENABLE_PADDING(0), .MIN_FRAME_LENGTH(60)) dut_np (
    .clk(clk), .rst_n(rst_n),
    .s_eth_hdr_valid(hdr_valid & sel_np), .s_eth_hdr_ready(hdr_ready_b),
    .s_eth_dest_mac(dest), .s_eth_src_mac(src), .s_eth_type(etype),
    .s_eth_payload_axis_tdata(p_tdata), .s_eth_payload_axis_tvalid(p_tvalid & sel_np),
    .s_eth_payload_axis_tready(p_tready_b), .s_eth_payload_axis_tlast(p_tlast),
    .s_eth_payload_axis_tuser(p_tuser),
    .m_axis_tdata(tdata_b), .m_axis_tvalid(tvalid_b), .m_axis_tready(m_tready),
    .m_axis_tlast(tlast_b), .m_axis_tuser(tuser_b), .busy(busy_b)
  );

  typedef struct {
    logic        np;
    logic        stall;
    logic [47:0] dest;
    logic [47:0] src;
    logic [15:0] etype;
    int          plen;
    logic [7:0]  pstart;
    logic        tuser_last;
    int          exp_len;
  } vec_t;

  typedef struct packed {
    logic       last;
    logic       user;
    logic [7:0] data;
  } beat_t;

  localparam int NVEC = 8;
  vec_t  vecs[NVEC];
  beat_t sb_q[$];
  int    checks = 0;
  int    errors = 0;
  int    frame_beats = 0;
  int    last_len = 0;
  logic  prev_stall = 1'b0;
  beat_t prev_beat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    m_tready = stall_mode ? 1'($urandom_range(1, 0)) : 1'b1;
  end

  // Output monitor: pops the scoreboard on every transfer and checks stall stability.
  always @(negedge clk) begin
    beat_t act, exp;
    act = '{last: m_tlast, user: m_tuser, data: m_tdata};
    if (!rst_n || !sb_en) begin
      prev_stall  = 1'b0;
      frame_beats = 0;
    end else begin
      if (prev_stall) check("stall_hold", 32'({m_tvalid, act}), 32'({1'b1, prev_beat}));
      if (m_tvalid && m_tready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_beat", 32'({m_tvalid, act}), 32'd0);
        end else begin
          exp = sb_q.pop_front();
          check("beat", 32'(act), 32'(exp));
        end
        frame_beats++;
        if (m_tlast) begin
          last_len    = frame_beats;
          frame_beats = 0;
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_beat  = act;
    end
  end

  task automatic push_frame(input vec_t v);
    logic [111:0] h;
    int n, total;
    beat_t b;
    h = {v.dest, v.src, v.etype};
    n = 14 + v.plen;
    total = (!v.np && n < 60) ? 60 : n;
    for (int k = 0; k < total; k++) begin
      if (k < 14)     b.data = h[111 - 8*k -: 8];
      else if (k < n) b.data = 8'(int'(v.pstart) + k - 14);
      else            b.data = 8'h00;
      b.last = (k == total - 1);
      b.user = (k == total - 1) ? v.tuser_last : 1'b0;
      sb_q.push_back(b);
    end
  endtask

  task automatic drive_hdr(input vec_t v);
    bit ok;
    int n;
    @(posedge clk); #1;
    hdr_valid = 1'b1; dest = v.dest; src = v.src; etype = v.etype;
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      if (hdr_ready) ok = 1'b1;
    end
    if (!ok) begin
      check("hdr_accept_timeout", 32'd0, 32'd1);
      hdr_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    hdr_valid = 1'b0;
    if (!v.stall) begin
      n = 0;
      for (int i = 1; i <= 10 && n == 0; i++) begin
        @(negedge clk);
        if (m_tvalid) n = i;
      end
      check("first_byte_latency", 32'(n), 32'd3);
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l, input logic u, output bit ok);
    p_tvalid = 1'b1; p_tdata = d; p_tlast = l; p_tuser = u;
    ok = 1'b0;
    for (int t = 0; t < 3000 && !ok; t++) begin
      @(negedge clk);
      if (p_tready) ok = 1'b1;
    end
    if (!ok) check("payload_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic send_payload(input vec_t v);
    bit ok;
    @(posedge clk); #1;
    for (int i = 0; i < v.plen; i++) begin
      if (v.stall) begin
        while ($urandom_range(1, 0) == 0) begin
          p_tvalid = 1'b0;
          @(posedge clk); #1;
        end
      end
      send_beat(8'(int'(v.pstart) + i), i == v.plen - 1, (i == v.plen - 1) && v.tuser_last, ok);
      if (!ok) break;
    end
    p_tvalid = 1'b0; p_tlast = 1'b0; p_tuser = 1'b0;
  endtask

  task automatic run_case(input int idx);
    vec_t v;
    bit ok;
    v = vecs[idx];
    sel_np = v.np;
    stall_mode = v.stall;
    push_frame(v);
    fork
      drive_hdr(v);
      send_payload(v);
    join
    ok = 1'b0;
    for (int t = 0; t < 5000 && !ok; t++) begin
      @(negedge clk);
      if (sb_q.size() == 0) ok = 1'b1;
    end
    if (!ok) check("drain_timeout", 32'(sb_q.size()), 32'd0);
    check("frame_len", 32'(last_len), 32'(v.exp_len));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("busy_after_frame", 32'(busy), 32'd0);
    stall_mode = 1'b0;
    sb_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    bit ok;
    rst_n = 1'b0; sel_np = 1'b0; stall_mode = 1'b0; sb_en = 1'b0;
    hdr_valid = 1'b0; dest = '0; src = '0; etype = '0;
    p_tdata = '0; p_tvalid = 1'b0; p_tlast = 1'b0; p_tuser = 1'b0;

    vecs[0] = '{np:1'b0, stall:1'b0, dest:48'hffffffffffff, src:48'h020000000001, etype:16'h0806,
                plen:28, pstart:8'h01, tuser_last:1'b0, exp_len:60};
    vecs[1] = '{np:1'b1, stall:1'b0, dest:48'hffffffffffff, src:48'h020000000001, etype:16'h0806,
                plen:28, pstart:8'h01, tuser_last:1'b0, exp_len:42};
    vecs[2] = '{np:1'b0, stall:1'b0, dest:48'h001122334455, src:48'h66778899aabb, etype:16'h0800,
                plen:100, pstart:8'h00, tuser_last:1'b0, exp_len:114};
    vecs[3] = '{np:1'b0, stall:1'b1, dest:48'hffffffffffff, src:48'h020000000001, etype:16'h0806,
                plen:28, pstart:8'h01, tuser_last:1'b0, exp_len:60};
    vecs[4] = '{np:1'b0, stall:1'b1, dest:48'h001122334455, src:48'h66778899aabb, etype:16'h0800,
                plen:100, pstart:8'h00, tuser_last:1'b1, exp_len:114};
    vecs[5] = '{np:1'b0, stall:1'b0, dest:48'h0a0b0c0d0e0f, src:48'h020000000002, etype:16'h88b5,
                plen:10, pstart:8'h40, tuser_last:1'b1, exp_len:60};
    vecs[6] = '{np:1'b0, stall:1'b0, dest:48'h0a0b0c0d0e0f, src:48'h020000000002, etype:16'h88b5,
                plen:46, pstart:8'h80, tuser_last:1'b1, exp_len:60};
    vecs[7] = '{np:1'b0, stall:1'b0, dest:48'h0a0b0c0d0e0f, src:48'h020000000002, etype:16'h88b5,
                plen:45, pstart:8'hc0, tuser_last:1'b0, exp_len:60};

    #12;
    check("rst_hdr_ready",  32'(hdr_ready_a), 32'd0);
    check("rst_pay_tready", 32'(p_tready_a),  32'd0);
    check("rst_tvalid",     32'(tvalid_a),    32'd0);
    check("rst_tlast",      32'(tlast_a),     32'd0);
    check("rst_tuser",      32'(tuser_a),     32'd0);
    check("rst_tdata",      32'(tdata_a),     32'd0);
    check("rst_busy",       32'(busy_a),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("hdr_ready_before_edge", 32'(hdr_ready_a), 32'd0);
    @(posedge clk); #1;
    check("hdr_ready_after_edge", 32'(hdr_ready_a), 32'd1);
    sb_en = 1'b1;

    for (int i = 0; i < NVEC; i++) run_case(i);

    // Reset in the middle of the payload, then a clean frame afterwards.
    sb_en = 1'b0;
    sel_np = 1'b0;
    drive_hdr(vecs[0]);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      send_beat(8'(i + 1), 1'b0, 1'b0, ok);
    end
    p_tvalid = 1'b1; p_tdata = 8'h05;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tvalid",    32'(tvalid_a),    32'd0);
    check("midrst_busy",      32'(busy_a),      32'd0);
    check("midrst_hdr_ready", 32'(hdr_ready_a), 32'd0);
    check("midrst_pay_ready", 32'(p_tready_a),  32'd0);
    p_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("midrst_hdr_ready_held", 32'(hdr_ready_a), 32'd0);
    @(posedge clk); #1;
    check("midrst_hdr_ready_back", 32'(hdr_ready_a), 32'd1);
    sb_q.delete();
    sb_en = 1'b1;
    run_case(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
